// File: rtl/hc02_tester_pkg.sv
// Shared types and constants for the 74HC02 quad-NOR gate tester.
package hc02_tester_pkg;

  localparam int unsigned NUM_GATES_DEF     = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;
  localparam int unsigned NUM_VEC           = 4;
  localparam int unsigned ERR_W             = $clog2(4 * NUM_GATES_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
  } vec_t;

  // Gray-ordered stimulus; entry 0 is the least significant element.
  localparam vec_t [NUM_VEC-1:0] VEC_ROM = {vec_t'(2'b01), vec_t'(2'b11),
                                            vec_t'(2'b10), vec_t'(2'b00)};

  function automatic logic expected_nor(input logic a, input logic b);
    return ~(a | b);
  endfunction

  function automatic int unsigned err_width(input int unsigned n);
    return $clog2(4 * n + 1);
  endfunction

endpackage

// File: rtl/hc02_gate_tester_if.sv
// Control/result and gate-side bus of the gate tester.
interface hc02_gate_tester_if
  import hc02_tester_pkg::*;
#(
  parameter int unsigned NUM_GATES = NUM_GATES_DEF
);

  localparam int unsigned ERR_BITS = err_width(NUM_GATES);

  logic                 start;
  logic                 abort;
  logic [NUM_GATES-1:0] drv_a;
  logic [NUM_GATES-1:0] drv_b;
  logic [NUM_GATES-1:0] dut_y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_GATES-1:0] fail_mask;
  logic [ERR_BITS-1:0]  err_count;
  logic [1:0]           first_fail_vec;

  modport master (
    output start, abort, dut_y,
    input  drv_a, drv_b, busy, done, pass, fail_mask, err_count, first_fail_vec
  );

  modport slave (
    input  start, abort, dut_y,
    output drv_a, drv_b, busy, done, pass, fail_mask, err_count, first_fail_vec
  );

endinterface

// File: rtl/hc_sync2.sv
// Parameterized-width two-flop synchronizer with async active-low reset.
module hc_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hc02_gate_tester.sv
// Sequential tester: applies the four NOR input vectors to every gate and
// scores the synchronized outputs into per-gate and aggregate results.
module hc02_gate_tester
  import hc02_tester_pkg::*;
#(
  parameter int unsigned NUM_GATES     = NUM_GATES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  hc02_gate_tester_if.slave   bus
);

  localparam int unsigned ERR_BITS  = err_width(NUM_GATES);
  localparam int unsigned CNT_W     = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       VIDX_LAST = 2'(NUM_VEC - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           vidx_q, vidx_d;
  logic [NUM_GATES-1:0] drv_a_q, drv_a_d, drv_b_q, drv_b_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
  logic [ERR_BITS-1:0]  err_q, err_d;
  vec_t                 ffv_q, ffv_d;

  logic [NUM_GATES-1:0] ysync;
  logic [NUM_GATES-1:0] exp_y;
  logic [NUM_GATES-1:0] mism;
  logic [ERR_BITS-1:0]  mism_cnt;
  vec_t                 cur_vec, nxt_vec;

  hc_sync2 #(.W(NUM_GATES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.dut_y),
    .q     (ysync)
  );

  assign cur_vec = VEC_ROM[vidx_q];
  assign nxt_vec = VEC_ROM[2'(vidx_q + 2'd1)];
  assign exp_y   = {NUM_GATES{expected_nor(cur_vec.a, cur_vec.b)}};
  assign mism    = ysync ^ exp_y;

  always_comb begin
    mism_cnt = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      mism_cnt = mism_cnt + ERR_BITS'(mism[g]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vidx_q      <= '0;
      drv_a_q     <= '0;
      drv_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_q       <= '0;
      ffv_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vidx_q      <= vidx_d;
      drv_a_q     <= drv_a_d;
      drv_b_q     <= drv_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_q       <= err_d;
      ffv_q       <= ffv_d;
    end
  end

  // Next-state and next-output logic; abort overrides every active state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vidx_d      = vidx_q;
    drv_a_d     = drv_a_q;
    drv_b_d     = drv_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_d       = err_q;
    ffv_d       = ffv_q;

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      drv_a_d = '0;
      drv_b_d = '0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            fail_mask_d = '0;
            err_d       = '0;
            ffv_d       = '0;
            pass_d      = 1'b0;
            vidx_d      = '0;
            drv_a_d     = {NUM_GATES{VEC_ROM[0].a}};
            drv_b_d     = {NUM_GATES{VEC_ROM[0].b}};
            cnt_d       = CNT_LOAD;
            busy_d      = 1'b1;
            state_d     = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_d = SAMPLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        SAMPLE: begin
          fail_mask_d = fail_mask_q | mism;
          err_d       = err_q + mism_cnt;
          if ((mism != '0) && (fail_mask_q == '0)) ffv_d = cur_vec;
          if (vidx_q != VIDX_LAST) begin
            vidx_d  = 2'(vidx_q + 2'd1);
            drv_a_d = {NUM_GATES{nxt_vec.a}};
            drv_b_d = {NUM_GATES{nxt_vec.b}};
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            done_d  = 1'b1;
            pass_d  = ((fail_mask_q | mism) == '0);
            drv_a_d = '0;
            drv_b_d = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.drv_a          = drv_a_q;
  assign bus.drv_b          = drv_b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_mask      = fail_mask_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_hc02_gate_tester.sv
// Bench for hc02_gate_tester: faultable NOR gate models on dut_y, a run-level
// behavioural model compared every cycle, and directed literal checks.
module tb_hc02_gate_tester;
  import hc02_tester_pkg::*;

  localparam int unsigned NG = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  hc02_gate_tester_if #(.NUM_GATES(NG)) bus ();

  hc02_gate_tester #(.NUM_GATES(NG), .SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Gate behaviour: 0 ideal NOR, 1 stuck-at-0, 2 stuck-at-1, 3 wired as OR.
  int mode [NG];
  logic [NG-1:0] gy;

  function automatic logic gate_out(input int m, input logic a, input logic b);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  always_comb begin
    gy = '0;
    for (int g = 0; g < NG; g++) gy[g] = gate_out(mode[g], bus.drv_a[g], bus.drv_b[g]);
  end
  assign bus.dut_y = gy;

  // Vector v of the Gray sequence 00,10,11,01.
  function automatic logic va(input int v); return (v == 1) || (v == 2); endfunction
  function automatic logic vb(input int v); return (v >= 2); endfunction

  typedef struct packed {
    logic [NG-1:0] mask;
    logic [7:0]    err;
    logic [1:0]    ffv;
  } res_t;

  // Results after the first n vectors have been scored.
  function automatic res_t fold(input int n);
    res_t r;
    r = '0;
    for (int v = 0; v < n; v++) begin
      for (int g = 0; g < NG; g++) begin
        if (gate_out(mode[g], va(v), vb(v)) != !(va(v) || vb(v))) begin
          if (r.mask == '0) r.ffv = {va(v), vb(v)};
          r.mask[g] = 1'b1;
          r.err     = r.err + 8'd1;
        end
      end
    end
    return r;
  endfunction

  // Run model: k counts clock edges since the accepted start.
  logic m_run;
  int   m_k;
  logic m_pass;
  res_t m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_k    <= 0;
      m_pass <= 1'b0;
      m_res  <= '0;
    end else if (!m_run) begin
      if (bus.start && !bus.abort) begin
        m_run  <= 1'b1;
        m_k    <= 0;
        m_pass <= 1'b0;
        m_res  <= '0;
      end
    end else if (bus.abort) begin
      m_run  <= 1'b0;
      m_pass <= 1'b0;
    end else if (m_k + 1 > 20) begin
      m_run <= 1'b0;
    end else begin
      m_k   <= m_k + 1;
      m_res <= fold((m_k + 1) / 5);
      if (m_k + 1 == 20) m_pass <= (fold(4).mask == '0);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  logic [NG-1:0] e_drv_a, e_drv_b;
  always_comb begin
    e_drv_a = '0;
    e_drv_b = '0;
    if (m_run && (m_k < 20)) begin
      e_drv_a = {NG{va(m_k / 5)}};
      e_drv_b = {NG{vb(m_k / 5)}};
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("busy",      32'(bus.busy),           32'(m_run));
      chk("done",      32'(bus.done),           32'(m_run && (m_k == 20)));
      chk("drv_a",     32'(bus.drv_a),          32'(e_drv_a));
      chk("drv_b",     32'(bus.drv_b),          32'(e_drv_b));
      chk("pass",      32'(bus.pass),           32'(m_pass));
      chk("fail_mask", 32'(bus.fail_mask),      32'(m_res.mask));
      chk("err_count", 32'(bus.err_count),      32'(m_res.err));
      chk("first_ffv", 32'(bus.first_fail_vec), 32'(m_res.ffv));
    end
  end

  logic [NG-1:0] tr_a [0:31];
  logic [NG-1:0] tr_b [0:31];

  // Start a run, optionally re-pulse start / assert abort at cycle index, watch done.
  task automatic run(input int pulse_at, input int abort_at, output int lat, output int ndone);
    lat   = -1;
    ndone = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      tr_a[i] = bus.drv_a;
      tr_b[i] = bus.drv_b;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      bus.start = (i == pulse_at);
      bus.abort = (i == abort_at);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic chk_res(input string nm, input logic p, input logic [NG-1:0] m,
                         input logic [31:0] e, input logic [1:0] f);
    chk({nm, "_pass"}, 32'(bus.pass),           32'(p));
    chk({nm, "_mask"}, 32'(bus.fail_mask),      32'(m));
    chk({nm, "_err"},  32'(bus.err_count),      e);
    chk({nm, "_ffv"},  32'(bus.first_fail_vec), 32'(f));
  endtask

  int lat, nd;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int g = 0; g < NG; g++) mode[g] = 0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", 32'(bus.busy),  32'd0);
    chk("rst_done", 32'(bus.done),  32'd0);
    chk("rst_drva", 32'(bus.drv_a), 32'd0);
    chk("rst_drvb", 32'(bus.drv_b), 32'd0);
    chk_res("rst", 1'b0, 4'b0000, 32'd0, 2'b00);
    #10 rst_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clk);
    #1;

    // Ideal gates
    run(0, 0, lat, nd);
    chk("ideal_lat",   32'(lat), 32'd20);
    chk("ideal_ndone", 32'(nd),  32'd1);
    chk_res("ideal", 1'b1, 4'b0000, 32'd0, 2'b00);
    chk("trace_v0", 32'({tr_a[2],  tr_b[2]}),  32'h00);
    chk("trace_v1", 32'({tr_a[6],  tr_b[6]}),  32'hF0);
    chk("trace_v2", 32'({tr_a[11], tr_b[11]}), 32'hFF);
    chk("trace_v3", 32'({tr_a[16], tr_b[16]}), 32'h0F);
    chk("trace_dn", 32'({tr_a[20], tr_b[20]}), 32'h00);

    // Gate 2 stuck-at-0
    mode[2] = 1;
    run(0, 0, lat, nd);
    chk_res("sa0g2", 1'b0, 4'b0100, 32'd1, 2'b00);

    // Gate 0 stuck-at-1, gate 3 wired as OR
    mode[2] = 0; mode[0] = 2; mode[3] = 3;
    run(0, 0, lat, nd);
    chk_res("sa1g0_org3", 1'b0, 4'b1001, 32'd7, 2'b00);

    // Gate 1 stuck-at-1: first failure is vector 10
    mode[0] = 0; mode[3] = 0; mode[1] = 2;
    run(0, 0, lat, nd);
    chk_res("sa1g1", 1'b0, 4'b0010, 32'd3, 2'b10);

    // Start re-pulsed mid-run is ignored
    mode[1] = 0;
    run(5, 0, lat, nd);
    chk("repulse_lat",   32'(lat), 32'd20);
    chk("repulse_ndone", 32'(nd),  32'd1);
    chk_res("repulse", 1'b1, 4'b0000, 32'd0, 2'b00);

    // Abort mid-run: no done, pass cleared, then a clean run
    run(0, 8, lat, nd);
    chk("abort_ndone", 32'(nd),        32'd0);
    chk("abort_pass",  32'(bus.pass),  32'd0);
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_drva",  32'(bus.drv_a), 32'd0);
    run(0, 0, lat, nd);
    chk("post_abort_ndone", 32'(nd),       32'd1);
    chk("post_abort_pass",  32'(bus.pass), 32'd1);

    // Asynchronous reset during vector 10 settling
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_drva", 32'(bus.drv_a), 32'hF);
    chk("pre_rst_busy", 32'(bus.busy),  32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_drva", 32'(bus.drv_a), 32'd0);
    chk("arst_drvb", 32'(bus.drv_b), 32'd0);
    chk("arst_busy", 32'(bus.busy),  32'd0);
    chk("arst_done", 32'(bus.done),  32'd0);
    chk_res("arst", 1'b0, 4'b0000, 32'd0, 2'b00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    run(0, 0, lat, nd);
    chk("post_rst_lat",  32'(lat),      32'd20);
    chk("post_rst_pass", 32'(bus.pass), 32'd1);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hc02_gate_tester.md
Name: hc02_gate_tester

Overview:
- Sequential on-board tester for quad 2-input NOR (74HC02-class) gates; the hardware counterpart of the hc02 stimulus/monitor bench.
- Drives the four input combinations onto every gate and samples the gate outputs back through a synchronizer.
- Checks each output against the expected NOR and reports per-gate pass/fail.
- Sits between the control logic (start/result) and the external or on-chip hc02 instances.

Parameters:
- NUM_GATES, 4, number of 2-input NOR gates under test, driven in parallel.
- SETTLE_CYCLES, 4, cycles held per vector before sampling; must be >=3 to cover the 2-flop synchronizer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a test run; ignored unless in IDLE.
- abort  in  1  terminate the run and return to IDLE; no done pulse.
- drv_a  out  NUM_GATES  A input to each gate (registered).
- drv_b  out  NUM_GATES  B input to each gate (registered).
- dut_y  in  NUM_GATES  gate outputs; asynchronous to clk.
- busy  out  1  high while a run is in progress (SETTLE, SAMPLE or DONE).
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  valid from done onward: 1 = no mismatches.
- fail_mask  out  NUM_GATES  bit g set if gate g mismatched on any vector.
- err_count  out  $clog2(4*NUM_GATES+1)  total mismatching (gate, vector) pairs.
- first_fail_vec  out  2  {a,b} of the first vector with any mismatch; 2'b00 if none.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; drv_a=drv_b=0; busy=done=pass=0; fail_mask=0; err_count=0; first_fail_vec=0. Reset mid-run aborts immediately, with no done pulse.
- Vector order (Gray), the same {a,b} on all gates: V0=00, V1=10, V2=11, V3=01. Expected y = ~(a|b), so only V0 expects 1.
- dut_y passes through a 2-flop synchronizer; compare uses the synchronized value (ysync).
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered, Moore style.
- IDLE, start=1 at edge E0:
  - clear fail_mask, err_count, first_fail_vec and pass;
  - drive V0; cnt<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: cnt decrements each cycle; go to SAMPLE when cnt==0. Drives stay stable.
- SAMPLE (one cycle):
  - mism = ysync ^ expected;
  - fail_mask |= mism; err_count += popcount(mism);
  - if mism!=0 and this is the first failing vector, latch first_fail_vec;
  - if vector index <3: drive the next vector, reload cnt, go to SETTLE;
  - otherwise go to DONE.
- DONE (one cycle): done=1; pass=(fail_mask==0); drives return to 0; next state IDLE.
- Timing: done rises at edge E0+4*(SETTLE_CYCLES+1). That is E0+20 at default, so busy is high for 21 cycles.
- pass, fail_mask, err_count and first_fail_vec hold their values until the next accepted start or reset.
- start while busy is ignored. Simultaneous start and abort in IDLE: abort wins, no run.
- abort in any non-IDLE state, including DONE: IDLE next cycle; drives=0; done not pulsed; pass=0; error fields keep partial values.
- err_count saturates by construction: its maximum is 4*NUM_GATES, so it never wraps.

Decomposition:
- Package hc02_tester_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - vector ROM constant (00,10,11,01);
  - function expected_nor(a,b);
  - ERR_W = $clog2(4*NUM_GATES+1).
- One sub-module: hc_sync2, a parameterized-width 2-flop synchronizer with async active-low reset, used on dut_y.

Test Plan:
- Ideal NOR model on dut_y, start pulse:
  - done at E0+20;
  - pass=1, fail_mask=4'b0000, err_count=0, first_fail_vec=2'b00;
  - drv_a/drv_b step through 0000/0000, 1111/0000, 1111/1111, 0000/1111.
- Gate 2 output stuck-at-0 → pass=0, fail_mask=4'b0100, err_count=1, first_fail_vec=2'b00.
- Gate 0 stuck-at-1 and gate 3 wired as OR:
  - fail_mask=4'b1001; err_count=3+4=7;
  - first_fail_vec=2'b00 (gate 3 fails V0).
- start re-pulsed at cycle 5 of a run → ignored: exactly one done at E0+20, results unchanged from the single-run values.
- abort asserted at cycle 8:
  - IDLE next cycle, drives=0, no done pulse, pass=0;
  - a new start then completes normally with pass=1.
- rst_n driven low asynchronously mid-SETTLE → all outputs 0 immediately, without a clock edge; after release, state is IDLE and busy=0.
